// File: rtl/matrix_loader.sv
// matrix_loader: assembles two DIMxDIM signed-byte matrices (A then B, row-major) from a
// valid/ready byte stream and presents them to the multiplier. Optional framing check: MATRIX_LOADER_FRAMECHK_EN.
module matrix_loader #(
    parameter int         ELEM_W  = 8,
    parameter int         DIM     = 5,
    parameter logic [2:0] OP_MUL  = 3'b010,
    parameter logic [2:0] OP_IDLE = 3'b000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ELEM_W-1:0]          in_data,
    input  logic                       abort,
`ifdef MATRIX_LOADER_FRAMECHK_EN
    input  logic                       in_last,
    output logic                       frame_err,
`endif
    output logic [DIM*DIM*ELEM_W-1:0]  Aa,
    output logic [DIM*DIM*ELEM_W-1:0]  Bb,
    output logic [2:0]                 op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [5:0]                 load_cnt,
    output logic [15:0]                frame_cnt
);
    localparam int         NEL    = DIM * DIM;
    localparam logic [5:0] LAST_A = 6'(NEL - 1);
    localparam logic [5:0] LAST_B = 6'(2 * NEL - 1);

    typedef enum logic [1:0] {LOAD_A, LOAD_B, PRESENT} state_e;

    state_e              state_q;
    logic                ready_q;
    logic                valid_q;
    logic [2:0]          op_q;
    logic [5:0]          cnt_q;
    logic [15:0]         frames_q;
    logic [ELEM_W-1:0]   a_q [NEL];
    logic [ELEM_W-1:0]   b_q [NEL];

    logic accept;
    logic frame_bad;

    assign accept = in_valid && ready_q;

`ifdef MATRIX_LOADER_FRAMECHK_EN
    logic err_q;

    // in_last must coincide exactly with the 50th byte of a frame
    assign frame_bad = accept && (in_last != (cnt_q == LAST_B));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (abort) begin
            err_q <= 1'b0;
        end else if (frame_bad) begin
            err_q <= 1'b1;
        end
    end

    assign frame_err = err_q;
`else
    assign frame_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LOAD_A;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            op_q     <= OP_IDLE;
            cnt_q    <= '0;
            frames_q <= '0;
            for (int k = 0; k < NEL; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else if (abort) begin
            state_q <= LOAD_A;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            op_q    <= OP_IDLE;
            cnt_q   <= '0;
        end else if (frame_bad) begin
            state_q <= LOAD_A;
            ready_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        for (int k = 0; k < NEL; k++) begin
                            if (cnt_q == 6'(k)) a_q[k] <= in_data;
                        end
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == LAST_A) state_q <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        for (int k = 0; k < NEL; k++) begin
                            if (cnt_q == 6'(k + NEL)) b_q[k] <= in_data;
                        end
                        if (cnt_q == LAST_B) begin
                            state_q <= PRESENT;
                            ready_q <= 1'b0;
                            valid_q <= 1'b1;
                            op_q    <= OP_MUL;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                        end
                    end
                end
                PRESENT: begin
                    ready_q <= 1'b0;
                    if (out_ready) begin
                        state_q  <= LOAD_A;
                        ready_q  <= 1'b1;
                        valid_q  <= 1'b0;
                        op_q     <= OP_IDLE;
                        frames_q <= frames_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= LOAD_A;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    op_q    <= OP_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < NEL; gi++) begin : g_pack
        assign Aa[gi*ELEM_W +: ELEM_W] = a_q[gi];
        assign Bb[gi*ELEM_W +: ELEM_W] = b_q[gi];
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign op        = op_q;
    assign load_cnt  = cnt_q;
    assign frame_cnt = frames_q;
endmodule

// File: tb/tb_matrix_loader.sv
// Bench for matrix_loader: table of whole-frame vectors, randomised gap/data frames against a
// frame-level model, and hand sequences for hold, abort, async reset and (if enabled) framing errors.
module tb_matrix_loader;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [7:0]   in_data = 8'h00;
    logic         abort = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic [199:0] Aa;
    logic [199:0] Bb;
    logic [2:0]   op;
    logic         out_valid;
    logic [5:0]   load_cnt;
    logic [15:0]  frame_cnt;
`ifdef MATRIX_LOADER_FRAMECHK_EN
    logic         in_last = 1'b0;
    logic         frame_err;
`endif

    always #5 clk = ~clk;

    matrix_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .abort     (abort),
`ifdef MATRIX_LOADER_FRAMECHK_EN
        .in_last   (in_last),
        .frame_err (frame_err),
`endif
        .Aa        (Aa),
        .Bb        (Bb),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .load_cnt  (load_cnt),
        .frame_cnt (frame_cnt)
    );

    typedef struct {
        logic [7:0] base;
        logic [7:0] step;
        int         gap_pct;
        logic [7:0] exp_a0;
        logic [7:0] exp_b24;
    } vec_t;

    int         checks = 0;
    int         failures = 0;
    int         exp_frames = 0;
    logic [7:0] frame_data [50];

    task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected packed bus: element k of the half starting at frame byte off
    function automatic logic [199:0] pack(input int off);
        logic [199:0] r;
        r = '0;
        for (int k = 0; k < 25; k++) r[k*8 +: 8] = frame_data[off + k];
        return r;
    endfunction

    task automatic fill_linear(input logic [7:0] base, input logic [7:0] step);
        for (int k = 0; k < 50; k++) frame_data[k] = 8'(int'(base) + k * int'(step));
    endtask

    // Offer one byte after some idle cycles; returns at the negedge after it was accepted
    task automatic send_byte(input logic [7:0] d, input logic last, input int gaps);
        int n;
        n = 0;
        in_valid = 1'b0;
        repeat (gaps) @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
`ifdef MATRIX_LOADER_FRAMECHK_EN
        in_last  = last;
`else
        if (last) n = 0;
`endif
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
`ifdef MATRIX_LOADER_FRAMECHK_EN
        in_last  = 1'b0;
`endif
    endtask

    task automatic do_ack(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_frames = (exp_frames + 1) % 65536;
        chk({tag, "_ack_out_valid"}, out_valid, 1'b0);
        chk({tag, "_ack_op"}, op, 3'b000);
        chk({tag, "_ack_frame_cnt"}, frame_cnt, exp_frames);
        chk({tag, "_ack_in_ready"}, in_ready, 1'b1);
    endtask

    task automatic run_frame(input int gap_pct, input bit ack, input string tag);
        int gaps;
        for (int k = 0; k < 50; k++) begin
            gaps = (int'($urandom_range(99)) < gap_pct) ? 1 : 0;
            send_byte(frame_data[k], k == 49, gaps);
        end
        chk({tag, "_out_valid"}, out_valid, 1'b1);
        chk({tag, "_op"}, op, 3'b010);
        chk({tag, "_in_ready"}, in_ready, 1'b0);
        chk({tag, "_load_cnt"}, load_cnt, 6'd0);
        chk({tag, "_Aa"}, Aa, pack(0));
        chk({tag, "_Bb"}, Bb, pack(25));
        $display("frame %s gap=%0d%%: Aa=%h Bb=%h", tag, gap_pct, Aa, Bb);
        if (ack) do_ack(tag);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs [4];
        logic [199:0] a_run, b_run;

        vecs[0] = '{base: 8'h00, step: 8'h05, gap_pct: 50, exp_a0: 8'h00, exp_b24: 8'hF5};
        vecs[1] = '{base: 8'h80, step: 8'h01, gap_pct: 25, exp_a0: 8'h80, exp_b24: 8'hB1};
        vecs[2] = '{base: 8'hFF, step: 8'hFF, gap_pct: 0,  exp_a0: 8'hFF, exp_b24: 8'hCE};
        vecs[3] = '{base: 8'h7F, step: 8'h02, gap_pct: 75, exp_a0: 8'h7F, exp_b24: 8'hE1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_Aa", Aa, '0);
        chk("rst_Bb", Bb, '0);
        chk("rst_op", op, 3'b000);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_load_cnt", load_cnt, 6'd0);
        chk("rst_frame_cnt", frame_cnt, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);

        // Gap-free bytes 0..49, then hold while a byte is offered
        fill_linear(8'h00, 8'h01);
        run_frame(0, 1'b0, "base");
        in_valid = 1'b1;
        in_data  = 8'hAA;
        repeat (10) @(negedge clk);
        chk("hold_out_valid", out_valid, 1'b1);
        chk("hold_load_cnt", load_cnt, 6'd0);
        chk("hold_Aa", Aa, pack(0));
        chk("hold_Bb", Bb, pack(25));
        chk("hold_frame_cnt", frame_cnt, 16'd0);
        in_valid = 1'b0;
        do_ack("hold");
        chk("after_ack_Aa", Aa, pack(0));

        // Table-driven whole frames
        for (int i = 0; i < 4; i++) begin
            fill_linear(vecs[i].base, vecs[i].step);
            run_frame(vecs[i].gap_pct, 1'b1, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_a0", i), Aa[7:0], vecs[i].exp_a0);
            chk($sformatf("vec%0d_b24", i), Bb[199:192], vecs[i].exp_b24);
        end

        // Extreme values interleaved with random data; gapped run must match gap-free run
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 50; k++) begin
                case (k % 4)
                    0: frame_data[k] = 8'h80;
                    1: frame_data[k] = 8'(($urandom));
                    2: frame_data[k] = 8'h7F;
                    default: frame_data[k] = 8'hFF;
                endcase
            end
            run_frame(0, 1'b1, $sformatf("rnd%0d_nogap", r));
            a_run = Aa;
            b_run = Bb;
            run_frame(50, 1'b1, $sformatf("rnd%0d_gap", r));
            chk($sformatf("rnd%0d_same_Aa", r), Aa, a_run);
            chk($sformatf("rnd%0d_same_Bb", r), Bb, b_run);
        end

        // Abort in LOAD_B together with an offered byte
        fill_linear(8'h10, 8'h03);
        for (int k = 0; k < 30; k++) send_byte(frame_data[k], 1'b0, 0);
        chk("pre_abort_load_cnt", load_cnt, 6'd30);
        in_valid = 1'b1;
        in_data  = 8'h55;
        abort    = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_load_cnt", load_cnt, 6'd0);
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_frame_cnt", frame_cnt, exp_frames);
        chk("abort_Aa_kept", Aa, pack(0));
        chk("abort_Bb_kept", Bb[39:0], pack(25) & 200'hFF_FFFF_FFFF);
        $display("abort in LOAD_B after 30 bytes: load_cnt=%0d", load_cnt);
        fill_linear(8'hC0, 8'h07);
        run_frame(30, 1'b1, "post_abort");

        // Abort while presenting: beats out_ready, no frame counted
        fill_linear(8'h33, 8'h0B);
        run_frame(0, 1'b0, "abort_present");
        abort     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        out_ready = 1'b0;
        chk("abort_pres_out_valid", out_valid, 1'b0);
        chk("abort_pres_op", op, 3'b000);
        chk("abort_pres_frame_cnt", frame_cnt, exp_frames);
        chk("abort_pres_Aa_kept", Aa, pack(0));

        // Asynchronous reset mid-LOAD_A
        fill_linear(8'h21, 8'h13);
        for (int k = 0; k < 10; k++) send_byte(frame_data[k], 1'b0, 0);
        #2 rst_n = 1'b0;
        #1;
        exp_frames = 0;
        chk("arst_a_Aa", Aa, '0);
        chk("arst_a_load_cnt", load_cnt, 6'd0);
        chk("arst_a_frame_cnt", frame_cnt, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(0, 1'b1, "post_rst_a");

        // Asynchronous reset mid-PRESENT
        fill_linear(8'h9C, 8'h05);
        run_frame(0, 1'b0, "pre_rst_p");
        #2 rst_n = 1'b0;
        #1;
        exp_frames = 0;
        chk("arst_p_out_valid", out_valid, 1'b0);
        chk("arst_p_op", op, 3'b000);
        chk("arst_p_Aa", Aa, '0);
        chk("arst_p_Bb", Bb, '0);
        chk("arst_p_frame_cnt", frame_cnt, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        fill_linear(8'h01, 8'h11);
        run_frame(20, 1'b1, "post_rst_p");

`ifdef MATRIX_LOADER_FRAMECHK_EN
        // Early in_last on byte 40
        fill_linear(8'h40, 8'h01);
        for (int k = 0; k <= 40; k++) send_byte(frame_data[k], k == 40, 0);
        chk("early_last_frame_err", frame_err, 1'b1);
        chk("early_last_out_valid", out_valid, 1'b0);
        chk("early_last_load_cnt", load_cnt, 6'd0);
        $display("early in_last at byte 40: frame_err=%b", frame_err);
        fill_linear(8'h50, 8'h03);
        run_frame(0, 1'b0, "framechk_good");
        chk("good_frame_err_sticky", frame_err, 1'b1);
        do_ack("framechk_good");
        // Missing in_last on byte 49
        for (int k = 0; k < 50; k++) send_byte(frame_data[k], 1'b0, 0);
        chk("no_last_out_valid", out_valid, 1'b0);
        chk("no_last_load_cnt", load_cnt, 6'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_clears_frame_err", frame_err, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
